// File: rtl/adc_scan_sequencer.sv
// Scan controller for the modular ADC core: walks channels FIRST_CH..FIRST_CH+NUM_CH-1,
// averages 2**AVG_LOG2 samples each. Optional response timeout: define ADC_SEQ_TIMEOUT_EN.
module adc_scan_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int FIRST_CH    = 1,
  parameter int AVG_LOG2    = 2,
  parameter int DATA_W      = 12,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clock_clk,
  input  logic                     reset_sink_reset_n,
  input  logic                     start,
  input  logic                     continuous,
  input  logic                     clear_err,
  output logic                     command_valid,
  output logic [4:0]               command_channel,
  output logic                     command_startofpacket,
  output logic                     command_endofpacket,
  input  logic                     command_ready,
  input  logic                     response_valid,
  input  logic [4:0]               response_channel,
  input  logic [DATA_W-1:0]        response_data,
  output logic [NUM_CH*DATA_W-1:0] result_data,
  output logic [NUM_CH-1:0]        result_valid,
  output logic                     scan_done,
  output logic                     busy,
  output logic                     err_sticky
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                   state_q;
  logic [IDX_W-1:0]         idx_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [ACC_W-1:0]         acc_q;
  logic [NUM_CH*DATA_W-1:0] result_q;
  logic [NUM_CH-1:0]        rvalid_q;
  logic                     done_q;
  logic                     err_q;

  logic [4:0]               cmd_ch_s;
  logic [ACC_W-1:0]         sum_s;
  logic [DATA_W-1:0]        avg_s;
  logic                     resp_ok_s;
  logic                     tmo_hit_s;

  assign cmd_ch_s  = 5'(FIRST_CH) + 5'(idx_q);
  assign sum_s     = acc_q + ACC_W'(response_data);
  assign avg_s     = DATA_W'(sum_s >> AVG_LOG2);
  assign resp_ok_s = (response_channel == cmd_ch_s);

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  assign tmo_hit_s = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Timeout counter: held at zero outside WAIT so every entry into WAIT starts fresh
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      tmo_q <= '0;
    end else if (state_q != WAIT) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + TMO_W'(1);
    end
  end
`else
  logic unused_tmo_s;

  assign tmo_hit_s    = 1'b0;
  assign unused_tmo_s = (TIMEOUT_CYC > 0);
`endif

  // Scan FSM with accumulator, result registers and sticky error
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      rvalid_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // a new error later in this block overrides a simultaneous clear
      if (clear_err) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (start || continuous) begin
            state_q <= ISSUE;
            idx_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        ISSUE: begin
          if (command_ready) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (response_valid) begin
            if (!resp_ok_s) begin
              err_q   <= 1'b1;
              state_q <= ISSUE;
            end else if (cnt_q != CNT_LAST) begin
              acc_q   <= sum_s;
              cnt_q   <= cnt_q + CNT_W'(1);
              state_q <= ISSUE;
            end else begin
              result_q[int'(idx_q)*DATA_W +: DATA_W] <= avg_s;
              rvalid_q[idx_q] <= 1'b1;
              acc_q <= '0;
              cnt_q <= '0;
              if (idx_q == IDX_LAST) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                idx_q   <= idx_q + IDX_W'(1);
                state_q <= ISSUE;
              end
            end
          end else if (tmo_hit_s) begin
            err_q   <= 1'b1;
            state_q <= ISSUE;
          end
        end
        DONE: begin
          idx_q <= '0;
          if (continuous) begin
            state_q <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign command_valid         = (state_q == ISSUE);
  assign command_channel       = cmd_ch_s;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign result_data           = result_q;
  assign result_valid          = rvalid_q;
  assign scan_done             = done_q;
  assign busy                  = (state_q != IDLE);
  assign err_sticky            = err_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Self-checking bench for adc_scan_sequencer (NUM_CH=3, FIRST_CH=1, AVG_LOG2=2).
module tb_adc_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic        clear_err = 1'b0;
  logic        command_ready = 1'b0;
  logic        response_valid = 1'b0;
  logic [4:0]  response_channel = 5'd0;
  logic [11:0] response_data = 12'd0;

  logic        command_valid, command_sop, command_eop;
  logic [4:0]  command_channel;
  logic [35:0] result_data;
  logic [2:0]  result_valid;
  logic        scan_done, busy, err_sticky;

  int checks = 0;
  int failures = 0;
  int accepted = 0;
  logic [4:0]  exp_ch_q[$];
  logic [11:0] exp_res_q[$];

  adc_scan_sequencer #(
    .NUM_CH(3), .FIRST_CH(1), .AVG_LOG2(2), .DATA_W(12), .TIMEOUT_CYC(16)
  ) dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n), .start(start),
    .continuous(continuous), .clear_err(clear_err),
    .command_valid(command_valid), .command_channel(command_channel),
    .command_startofpacket(command_sop), .command_endofpacket(command_eop),
    .command_ready(command_ready), .response_valid(response_valid),
    .response_channel(response_channel), .response_data(response_data),
    .result_data(result_data), .result_valid(result_valid),
    .scan_done(scan_done), .busy(busy), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && command_valid && command_ready) accepted++;
  end

  // Serve one command: wait for it, check channel/stability, accept, then respond.
  task automatic serve_one(input logic [11:0] data, input bit bad_ch, input int ready_dly);
    int t;
    logic [4:0] exp;
    t = 0;
    while (!command_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (command_valid !== 1'b1) begin
      failures++;
      $display("FAIL cmd_wait: command_valid=%b required 1", command_valid);
      return;
    end
    checks++;
    if (exp_ch_q.size() == 0) begin
      failures++;
      $display("FAIL cmd_extra: channel %0d issued, none expected", command_channel);
      return;
    end
    exp = exp_ch_q.pop_front();
    if (command_channel !== exp || command_sop !== 1'b1 || command_eop !== 1'b1) begin
      failures++;
      $display("FAIL cmd_channel: got %0d sop=%b eop=%b required %0d", command_channel,
               command_sop, command_eop, exp);
    end
    for (int k = 0; k < ready_dly; k++) begin
      command_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (command_valid !== 1'b1 || command_channel !== exp) begin
        failures++;
        $display("FAIL cmd_hold: valid=%b ch=%0d required 1/%0d", command_valid,
                 command_channel, exp);
      end
    end
    command_ready = 1'b1;
    @(negedge clk);
    command_ready = 1'b0;
    checks++;
    if (command_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_no_cmd: command_valid=%b required 0", command_valid);
    end
    response_valid   = 1'b1;
    response_channel = bad_ch ? exp + 5'd1 : exp;
    response_data    = data;
    @(negedge clk);
    response_valid = 1'b0;
    if (bad_ch) begin
      checks++;
      if (err_sticky !== 1'b1) begin
        failures++;
        $display("FAIL err_set: err_sticky=%b required 1", err_sticky);
      end
    end
  endtask

  // Full scan of 3 channels, data base+step*s; checks results at the scan_done cycle.
  task automatic run_scan(input logic [11:0] base, input logic [11:0] step,
                          input bit inject_bad, input int ready_dly, input bit drop_cont);
    int sum;
    logic [11:0] d;
    logic [11:0] r;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int s = 0; s < 4; s++) begin
        d = base + step * 12'(s);
        if (ch == 0 && s == 0 && inject_bad) begin
          exp_ch_q.push_back(5'd1);
          serve_one(12'd999, 1'b1, 0);
        end
        exp_ch_q.push_back(5'(1 + ch));
        serve_one(d, 1'b0, (ch == 0 && s == 0) ? ready_dly : 0);
        sum += int'(d);
        if (ch == 0 && s == 3 && drop_cont) continuous = 1'b0;
      end
      exp_res_q.push_back(12'(sum / 4));
    end
    checks++;
    if (scan_done !== 1'b1) begin
      failures++;
      $display("FAIL scan_done: got %b required 1", scan_done);
    end
    for (int i = 0; i < 3; i++) begin
      r = exp_res_q.pop_front();
      checks++;
      if (result_data[i*12 +: 12] !== r) begin
        failures++;
        $display("FAIL result[%0d]: got %0d required %0d", i, result_data[i*12 +: 12], r);
      end
    end
    checks++;
    if (result_valid !== 3'b111) begin
      failures++;
      $display("FAIL result_valid: got %b required 111", result_valid);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || scan_done !== 1'b0 || command_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b valid=%b required 0/0/0", name, busy, scan_done,
               command_valid);
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (busy !== 1'b0 || scan_done !== 1'b0 || command_valid !== 1'b0 ||
        result_data !== 36'd0 || result_valid !== 3'b000 || err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL %s: busy=%b done=%b valid=%b res=%h rv=%b err=%b required all 0", name,
               busy, scan_done, command_valid, result_data, result_valid, err_sticky);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_scan();
    pulse_start();
    run_scan(12'd100, 12'd1, 1'b0, 0, 1'b0);
    check_idle("basic_idle");
    checks++;
    if (accepted !== 12) begin
      failures++;
      $display("FAIL basic_accepts: got %0d required 12", accepted);
    end
  endtask

  task automatic test_ready_backpressure();
    int base;
    base = accepted;
    pulse_start();
    run_scan(12'd100, 12'd1, 1'b0, 5, 1'b0);
    check_idle("bp_idle");
    checks++;
    if (accepted - base !== 12) begin
      failures++;
      $display("FAIL bp_accepts: got %0d required 12", accepted - base);
    end
  endtask

  task automatic test_channel_mismatch();
    int base;
    base = accepted;
    pulse_start();
    run_scan(12'd100, 12'd1, 1'b1, 0, 1'b0);
    check_idle("err_idle");
    checks++;
    if (accepted - base !== 13 || err_sticky !== 1'b1) begin
      failures++;
      $display("FAIL err_reissue: accepts=%0d err=%b required 13/1", accepted - base, err_sticky);
    end
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      failures++;
      $display("FAIL err_clear: got %b required 0", err_sticky);
    end
  endtask

  task automatic test_continuous();
    continuous = 1'b1;
    @(negedge clk);
    run_scan(12'd4095, 12'd0, 1'b0, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (command_valid !== 1'b1 || command_channel !== 5'd1 || scan_done !== 1'b0) begin
      failures++;
      $display("FAIL cont_restart: valid=%b ch=%0d done=%b required 1/1/0", command_valid,
               command_channel, scan_done);
    end
    run_scan(12'd4095, 12'd0, 1'b0, 0, 1'b1);
    check_idle("cont_stop_idle");
  endtask

  task automatic test_reset_in_wait();
    pulse_start();
    command_ready = 1'b1;
    @(negedge clk);
    command_ready = 1'b0;
    checks++;
    if (busy !== 1'b1 || command_valid !== 1'b0) begin
      failures++;
      $display("FAIL wait_state: busy=%b valid=%b required 1/0", busy, command_valid);
    end
    rst_n = 1'b0;
    #1;
    check_zero("reset_in_wait");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    run_scan(12'd200, 12'd3, 1'b0, 0, 1'b0);
    check_idle("post_reset_idle");
  endtask

`ifdef ADC_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    pulse_start();
    command_ready = 1'b1;
    @(negedge clk);
    command_ready = 1'b0;
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      if (err_sticky !== 1'b0 || command_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL tmo_early: %0d early cycles required 0", bad);
    end
    checks++;
    if (err_sticky !== 1'b1 || command_valid !== 1'b1 || command_channel !== 5'd1) begin
      failures++;
      $display("FAIL tmo_fire: err=%b valid=%b ch=%0d required 1/1/1", err_sticky,
               command_valid, command_channel);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_ready_backpressure();
    test_channel_mismatch();
    test_continuous();
    test_reset_in_wait();
`ifdef ADC_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
